// File: rtl/uart_rx_wb.sv
// uart_rx_wb: 8N1 UART receiver with RX FIFO behind a Wishbone B4 classic slave.
// Registers (wb_adr[3:2]): 0 DATA (read pops), 1 STATUS (bits 2/3 W1C), 2 CTRL (irq_en).
module uart_rx_wb #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        irq
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned CW           = AW + 1;
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic             rx_m, rx_s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             push_c, ferr_set_c;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             ovr, ferr, irq_en;

  logic             req_c, rd_c, wr_c, pop_c, push_ok_c, ovr_set_c;
  logic             clr_ovr_c, clr_ferr_c, not_empty_c, full_c;
  logic [1:0]       sel_c;
  logic [31:0]      rdata_c;
  logic             unused_c;

  assign unused_c = ^{wb_dat_i[31:4], wb_dat_i[1], wb_adr[1:0]};

  // Two-flop synchronizer for the asynchronous rx pin, idles high
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receive FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state: mid-bit sampling; BREAK absorbs a held-low line after a framing error
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_LD;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            cnt_n     = FULL_LD;
            bit_idx_n = 3'd0;
            state_n   = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shreg_n   = {rx_s, shreg[7:1]};
          cnt_n     = FULL_LD;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push_c  = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_set_c = 1'b1;
            state_n    = S_BREAK;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bus decode, FIFO push/pop arbitration and read mux
  always_comb begin
    req_c       = wb_cyc & wb_stb & ~wb_ack;
    rd_c        = req_c & ~wb_we;
    wr_c        = req_c & wb_we;
    sel_c       = wb_adr[3:2];
    not_empty_c = (count != '0);
    full_c      = (count == CW'(FIFO_DEPTH));
    pop_c       = rd_c & (sel_c == 2'd0) & not_empty_c;
    push_ok_c   = push_c & (~full_c | pop_c);
    ovr_set_c   = push_c & full_c & ~pop_c;
    clr_ovr_c   = wr_c & (sel_c == 2'd1) & wb_dat_i[2];
    clr_ferr_c  = wr_c & (sel_c == 2'd1) & wb_dat_i[3];
    rdata_c     = '0;
    case (sel_c)
      2'd0: if (not_empty_c) rdata_c = {24'b0, mem[rd_ptr]};
      2'd1: begin
        rdata_c[0]       = not_empty_c;
        rdata_c[1]       = full_c;
        rdata_c[2]       = ovr;
        rdata_c[3]       = ferr;
        rdata_c[4 +: CW] = count;
      end
      2'd2: rdata_c[0] = irq_en;
      default: rdata_c = '0;
    endcase
  end

  // FIFO storage; no reset needed, emptiness is tracked by count
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags (set beats clear), control, bus response and interrupt
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovr      <= 1'b0;
      ferr     <= 1'b0;
      irq_en   <= 1'b0;
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
      irq      <= 1'b0;
    end else begin
      ovr      <= ovr_set_c | (ovr & ~clr_ovr_c);
      ferr     <= ferr_set_c | (ferr & ~clr_ferr_c);
      if (wr_c && sel_c == 2'd2) irq_en <= wb_dat_i[0];
      wb_ack   <= req_c;
      wb_dat_o <= rd_c ? rdata_c : 32'd0;
      irq      <= irq_en & not_empty_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_wb.sv
// tb_uart_rx_wb: directed UART frames and bus accesses; reads queue their expected
// data, and a monitor compares every acked read against the queue head.
module tb_uart_rx_wb;

  localparam int unsigned BIT_CLKS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_adr = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack, irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];

  uart_rx_wb #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp_v);
    end
  endtask

  // Monitor: each ack pops one scoreboard entry and compares read data
  always @(negedge clk) begin
    if (wb_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) check(e.nm, wb_dat_o, e.val);
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input logic [31:0] exp_v, input string nm);
    exp_t e;
    bit got;
    @(negedge clk);
    e.chk = ~we;
    e.val = exp_v;
    e.nm  = nm;
    sb.push_back(e);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wb_ack) got = 1'b1;
    end
    if (!got) check({nm, "_ack_timeout"}, 32'd0, 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] adr, input logic [31:0] exp_v, input string nm);
    wb_xfer(1'b0, adr, 32'd0, exp_v, nm);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
    wb_xfer(1'b1, adr, dat, 32'd0, "write");
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    logic [5:0] pat;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte
    send_byte(8'h55, 1'b1);
    rd(4'h4, 32'h0000_0011, "status_one");
    rd(4'h0, 32'h0000_0055, "data_55");
    rd(4'h4, 32'h0000_0000, "status_empty");

    // Overrun: 17 frames, no reads
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    rd(4'h4, 32'h0000_0107, "status_full_ovr");
    for (int i = 0; i < 16; i++) rd(4'h0, 32'(i), "data_fifo_order");
    rd(4'h0, 32'h0000_0000, "data_empty_read");
    rd(4'h4, 32'h0000_0004, "status_ovr_only");
    wr(4'h4, 32'h0000_0004);
    rd(4'h4, 32'h0000_0000, "status_ovr_cleared");

    // Framing error followed by a long break
    send_byte(8'hA3, 1'b0);
    rd(4'h4, 32'h0000_0008, "status_ferr");
    wr(4'h4, 32'h0000_0008);
    repeat (BIT_CLKS * 40) @(negedge clk);
    rd(4'h4, 32'h0000_0000, "status_break_no_refire");
    rx = 1'b1;
    repeat (BIT_CLKS * 2) @(negedge clk);
    rd(4'h4, 32'h0000_0000, "status_after_break");
    send_byte(8'h3C, 1'b1);
    rd(4'h4, 32'h0000_0011, "status_3c");
    rd(4'h0, 32'h0000_003C, "data_3c");

    // Start-bit glitch
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS * 12) @(negedge clk);
    rd(4'h4, 32'h0000_0000, "status_glitch");

    // Interrupt
    wr(4'h8, 32'h0000_0001);
    rd(4'h8, 32'h0000_0001, "ctrl_readback");
    repeat (2) @(negedge clk);
    check("irq_empty", {31'd0, irq}, 32'd0);
    send_byte(8'h7E, 1'b1);
    check("irq_pending", {31'd0, irq}, 32'd1);
    rd(4'h0, 32'h0000_007E, "data_7e");
    check("irq_at_pop", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_after_pop", {31'd0, irq}, 32'd0);
    wr(4'h8, 32'h0000_0000);
    send_byte(8'h11, 1'b1);
    repeat (2) @(negedge clk);
    check("irq_disabled", {31'd0, irq}, 32'd0);
    rd(4'h0, 32'h0000_0011, "data_11");

    // Reset in the middle of a frame, with state to clear
    wr(4'h8, 32'h0000_0001);
    send_byte(8'h21, 1'b1);
    @(negedge clk);
    check("irq_before_rst", {31'd0, irq}, 32'd1);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    check("midrst_ack", {31'd0, wb_ack}, 32'd0);
    check("midrst_dat", wb_dat_o, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    repeat (BIT_CLKS * 12) @(negedge clk);
    rd(4'h4, 32'h0000_0000, "status_midrst");
    rd(4'h8, 32'h0000_0000, "ctrl_midrst");
    send_byte(8'h42, 1'b1);
    rd(4'h4, 32'h0000_0011, "status_42");
    rd(4'h0, 32'h0000_0042, "data_42");

    // Continuous strobe: ack every other cycle, one pop per ack
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    send_byte(8'hA3, 1'b1);
    rd(4'h4, 32'h0000_0031, "status_three");
    @(negedge clk);
    begin
      exp_t e;
      e.chk = 1'b1; e.nm = "burst_data";
      e.val = 32'h0000_00A1; sb.push_back(e);
      e.val = 32'h0000_00A2; sb.push_back(e);
      e.val = 32'h0000_00A3; sb.push_back(e);
    end
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[5-i] = wb_ack;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check("ack_pattern", {26'd0, pat}, {26'd0, 6'b101010});
    rd(4'h4, 32'h0000_0000, "status_burst_drained");

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_wb.md
Name: uart_rx_wb

Overview:
- UART receiver, 8N1, exposed as a Wishbone B4 classic slave on the data crossbar. It is the receive-side counterpart of the console transmitter.
- Samples the asynchronous rx pin and deframes bytes into an RX FIFO.
- CPU reads bytes and status through three word registers.
- Provides a level interrupt when data is pending and the interrupt is enabled.

Parameters:
- CLK_FREQ, 50000000, bus clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, must be >= 4.
- FIFO_DEPTH, 16, RX FIFO entries. Must be a power of two.

Ports:
- clk  in  1  bus clock.
- rst  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- wb_cyc  in  1  bus cycle.
- wb_stb  in  1  strobe.
- wb_we  in  1  write enable.
- wb_adr  in  4  byte address; bits [3:2] select the register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack  out  1  acknowledge.
- irq  out  1  interrupt request.

Behaviour:
- Reset: all state is cleared on the clk edge where rst==0.
  - Outputs: wb_ack=0, wb_dat_o=0, irq=0.
  - FIFO empty, sticky flags 0, irq_en=0, FSM in IDLE.
  - Synchronizer flops are preset to 1.
  - Reset mid-frame abandons the partial byte. No byte is pushed afterwards.
- Input sync: rx passes through a 2-flop synchronizer (rx_s) before any use, adding 2 cycles of latency.
- FSM states:
  - IDLE: stay while rx_s==1. When rx_s==0, load the counter with CLKS_PER_BIT/2-1 and go to START.
  - START: when the counter expires, sample rx_s. If 0, load CLKS_PER_BIT-1, set bit_idx=0 and go to DATA. If 1, treat it as a glitch and return to IDLE.
  - DATA: at each expiry, shift rx_s in LSB-first and reload CLKS_PER_BIT-1. After bit_idx 7, go to STOP.
  - STOP: at expiry, sample rx_s.
    - If 1, push the byte and go to IDLE.
    - If 0, set ferr, discard the byte, and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from being read as a stream of 0x00 bytes.
- Push with FIFO full: the byte is dropped and ovr is set. Stored data is never overwritten.
- Push and pop in the same cycle:
  - When full: both occur, no overrun.
  - When empty: the read returns 0 and the byte is stored.
- Count width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Wishbone slave:
  - When wb_cyc&wb_stb&!wb_ack, assert wb_ack for exactly one cycle on the next edge.
  - wb_dat_o is valid in the ack cycle. Side effects occur once per transaction, on the ack edge.
  - No wait states and no error termination.
  - Back-to-back strobes ack every other cycle.
- Register map, addressed by wb_adr[3:2]:
  - 0 DATA, read-only.
    - Returns {24'b0, head byte} and pops the FIFO.
    - When the FIFO is empty, returns 0 with no pop.
    - Writes are ignored but still acked.
  - 1 STATUS.
    - Read: bit0 not_empty, bit1 full, bit2 ovr, bit3 ferr, bits[4+:W] count, remaining bits 0.
    - Write: bits 2 and 3 are write-1-to-clear.
    - A flag set event in the same cycle as a clear wins; the flag stays 1.
  - 2 CTRL, read/write.
    - bit0 irq_en; other bits read as 0.
  - 3 reserved: reads 0, writes are ignored.
- irq: registered, irq = irq_en & not_empty. It updates one cycle after the FIFO or irq_en changes.

Test Plan:
- CLK_FREQ=1600, BAUD=100 (16 clks/bit). After reset, drive frame 0x55 on rx.
  - STATUS reads 0x00000011 (not_empty, count=1).
  - DATA reads 0x00000055, then STATUS reads 0x00000000.
- Send 17 bytes 0x00..0x10 with no reads.
  - STATUS reads full=1, ovr=1, count=16.
  - 16 DATA reads return 0x00..0x0F in order; the 17th read returns 0.
  - Write STATUS=0x4; STATUS then reads 0.
- Send a frame 0xA3 with the stop bit low, then hold rx low for 40 bit times.
  - Exactly one ferr event is recorded and no byte is pushed; count=0.
  - After rx returns high, a 0x3C frame is received correctly.
- Drive a 4-cycle low glitch on idle rx.
  - No byte is pushed; the FSM returns to IDLE; STATUS reads 0.
- Write CTRL=1 with the FIFO empty: irq=0.
  - Receive 0x7E: irq rises one cycle after the push.
  - Read DATA: irq falls one cycle after the pop.
  - Write CTRL=0: irq stays 0 on the next byte.
- Drive rst=0 for one cycle mid-DATA of byte 0x99.
  - All outputs and STATUS read 0, and the next frame 0x42 is received correctly.
  - Separately, hold stb continuously: ack toggles 1,0,1,0 and each ack pops exactly one entry.
